// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: FSM state encoding and record layout.
// A record is packed as {pc, instr, wb}, pc in the most significant field.
package retire_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned REC_FIELDS = 3;

    function automatic int unsigned rec_width(input int unsigned xlen);
        return REC_FIELDS * xlen;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire-record input and oldest-first readout handshake of the trace buffer.
// The slave modport is the buffer; the master modport is core side + consumer.
interface retire_trace_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic [XLEN-1:0] ret_instr;
    logic [XLEN-1:0] ret_wb;

    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [XLEN-1:0] rd_instr;
    logic [XLEN-1:0] rd_wb;

    modport master (
        output ret_valid, ret_pc, ret_instr, ret_wb, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_wb
    );

    modport slave (
        input  ret_valid, ret_pc, ret_instr, ret_wb, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_wb
    );
endinterface

// File: rtl/retire_trace_buffer_ram.sv
// Record storage: DEPTH x W, synchronous write, asynchronous read.
// Contents are not reset; validity is tracked by the controller.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 96
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: circular record buffer with PC-match trigger and
// programmable post-trigger depth, drained oldest-first over rd_valid/rd_ready.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [$clog2(DEPTH):0]   post_count,
    retire_trace_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     triggered,
    output logic                     overflow,
    output logic                     busy
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned REC_W = rec_width(XLEN);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_e         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic           triggered_q, triggered_d;
    logic           overflow_q, overflow_d;
    logic           busy_q, busy_d;
    logic           rd_valid_q, rd_valid_d;

    logic             wr_en;
    logic             pc_hit;
    logic             pop;
    logic [REC_W-1:0] rd_rec;

    assign pc_hit = trig_en && bus.ret_valid && (bus.ret_pc == trig_pc);
    assign pop    = (state_q == ST_DONE) && rd_valid_q && bus.rd_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rem_d       = rem_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rem_d       = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED, ST_POST: begin
                    if (bus.ret_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q == FULL_C) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (state_q == ST_ARMED && pc_hit) begin
                        triggered_d = 1'b1;
                        if (post_count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                            rem_d   = post_count;
                        end
                    end
                    if (state_q == ST_POST && bus.ret_valid) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == ONE_C) begin
                            state_d = ST_DONE;
                        end
                    end
                    if (stop) begin
                        state_d = ST_DONE;
                    end
                    // Oldest record sits count entries behind the write pointer; a
                    // full buffer (count==DEPTH) truncates to rd_ptr == wr_ptr.
                    if (state_d == ST_DONE) begin
                        rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                    end
                end
                ST_DONE: begin
                    if (count_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                        if (count_q == ONE_C) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d     = (state_d == ST_ARMED) || (state_d == ST_POST);
        rd_valid_d = (state_d == ST_DONE) && (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rem_q       <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.ret_pc, bus.ret_instr, bus.ret_wb}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_rec)
    );

    // Read fields are forced to zero whenever no record is being offered.
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_pc    = rd_valid_q ? rd_rec[3*XLEN-1 -: XLEN] : '0;
    assign bus.rd_instr = rd_valid_q ? rd_rec[2*XLEN-1 -: XLEN] : '0;
    assign bus.rd_wb    = rd_valid_q ? rd_rec[XLEN-1:0]         : '0;

    assign count     = count_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer (DEPTH=8): a directed vector table,
// hand-written corner sequences, and randomized runs against a queue-based model.
module tb_retire_trace_buffer;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            arm, stop, trig_en;
    logic [XLEN-1:0] trig_pc;
    logic [CW-1:0]   post_count;
    logic [CW-1:0]   count;
    logic            triggered, overflow, busy;

    retire_trace_buffer_if #(.XLEN(XLEN)) bus ();

    retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .stop       (stop),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .bus        (bus.slave),
        .count      (count),
        .triggered  (triggered),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wb;
    } rec_t;

    typedef struct {
        bit          a;
        bit          s;
        bit          rv;
        logic [31:0] pc;
        bit          rdy;
        int          e_count;
        bit          e_valid;
        bit          e_busy;
        logic [31:0] e_pc;
    } vec_t;

    // Reference model: records held, plus capture/readout phase and sticky flags.
    rec_t mq[$];
    bit   m_capt, m_post, m_read, m_trig, m_ovf;
    int   m_rem;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pc);
        rec_t r;
        r.pc    = pc;
        r.instr = pc ^ 32'hA5A5_0013;
        r.wb    = pc * 3 + 32'd1;
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc    = 32'(4 * $urandom_range(0, 15));
        r.instr = $urandom;
        r.wb    = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_capt = 0; m_post = 0; m_read = 0; m_trig = 0; m_ovf = 0; m_rem = 0;
    endtask

    task automatic end_capture();
        m_capt = 0;
        m_post = 0;
        m_read = 1;
    endtask

    task automatic model_step(input bit a, input bit s, input bit rv, input rec_t r, input bit rdy);
        if (a) begin
            model_clear();
            m_capt = 1;
        end else if (m_capt) begin
            if (rv) begin
                mq.push_back(r);
                if (mq.size() > DEPTH) begin
                    void'(mq.pop_front());
                    m_ovf = 1;
                end
                if (m_post) begin
                    m_rem--;
                    if (m_rem == 0) end_capture();
                end else if (trig_en && r.pc == trig_pc) begin
                    m_trig = 1;
                    if (post_count == 0) end_capture();
                    else begin
                        m_post = 1;
                        m_rem  = int'(post_count);
                    end
                end
            end
            if (s && m_capt) end_capture();
        end else if (m_read) begin
            if (mq.size() == 0) m_read = 0;
            else if (rdy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_read = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".busy"}, busy, m_capt);
        chk({tag, ".count"}, count, mq.size());
        chk({tag, ".triggered"}, triggered, m_trig);
        chk({tag, ".overflow"}, overflow, m_ovf);
        chk({tag, ".rd_valid"}, bus.rd_valid, m_read && mq.size() > 0);
        if (m_read && mq.size() > 0) begin
            chk({tag, ".rd_pc"}, bus.rd_pc, mq[0].pc);
            chk({tag, ".rd_instr"}, bus.rd_instr, mq[0].instr);
            chk({tag, ".rd_wb"}, bus.rd_wb, mq[0].wb);
        end else if (!m_capt && !m_read) begin
            chk({tag, ".rd_pc_idle"}, bus.rd_pc, 0);
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one.
    task automatic tick(input string tag, input bit a, input bit s, input bit rv,
                        input rec_t r, input bit rdy);
        arm           = a;
        stop          = s;
        bus.ret_valid = rv;
        bus.ret_pc    = r.pc;
        bus.ret_instr = r.instr;
        bus.ret_wb    = r.wb;
        bus.rd_ready  = rdy;
        model_step(a, s, rv, r, rdy);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drain(input string tag, input bit rnd, input int budget);
        int   n = 0;
        rec_t z = '{default: 0};
        while ((m_read || bus.rd_valid) && n < budget) begin
            tick(tag, 0, 0, 0, z, rnd ? bit'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk({tag, ".drained"}, {bus.rd_valid, count}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        rec_t z = '{default: 0};
        logic [31:0] hold_pc;
        logic [CW-1:0] hold_cnt;

        reset = 1'b0;
        arm = 0; stop = 0; trig_en = 0; trig_pc = '0; post_count = '0;
        bus.ret_valid = 0; bus.ret_pc = '0; bus.ret_instr = '0; bus.ret_wb = '0;
        bus.rd_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset = 1'b1;
        tick("idle", 0, 0, 1, mk(32'h40), 1);

        // Test 1: plain capture and in-order readout, as a vector table.
        tbl[0] = '{a:1, s:0, rv:0, pc:0, rdy:0, e_count:0, e_valid:0, e_busy:1, e_pc:0};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{a:0, s:0, rv:1, pc:32'(4*(i-1)), rdy:0, e_count:i, e_valid:0, e_busy:1, e_pc:0};
        tbl[6] = '{a:0, s:1, rv:0, pc:0, rdy:0, e_count:5, e_valid:1, e_busy:0, e_pc:32'h00};
        for (int i = 7; i <= 10; i++)
            tbl[i] = '{a:0, s:0, rv:0, pc:0, rdy:1, e_count:11-i, e_valid:1, e_busy:0, e_pc:32'(4*(i-6))};
        tbl[11] = '{a:0, s:0, rv:0, pc:0, rdy:1, e_count:0, e_valid:0, e_busy:0, e_pc:0};
        tbl[12] = '{a:0, s:1, rv:1, pc:32'h99, rdy:1, e_count:0, e_valid:0, e_busy:0, e_pc:0};
        for (int i = 0; i < 13; i++) begin
            tick($sformatf("t1[%0d]", i), tbl[i].a, tbl[i].s, tbl[i].rv, mk(tbl[i].pc), tbl[i].rdy);
            chk($sformatf("t1v[%0d].count", i), count, tbl[i].e_count);
            chk($sformatf("t1v[%0d].rd_valid", i), bus.rd_valid, tbl[i].e_valid);
            chk($sformatf("t1v[%0d].busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_valid) chk($sformatf("t1v[%0d].rd_pc", i), bus.rd_pc, tbl[i].e_pc);
        end
        chk("t1.overflow", overflow, 0);
        chk("t1.triggered", triggered, 0);

        // Test 2: wrap past DEPTH.
        tick("t2", 1, 0, 0, z, 0);
        for (int i = 0; i < 11; i++) tick("t2", 0, 0, 1, mk(32'(4*i)), 0);
        tick("t2", 0, 1, 0, z, 0);
        chk("t2.overflow", overflow, 1);
        chk("t2.count", count, 8);
        chk("t2.first_pc", bus.rd_pc, 32'h0C);
        drain("t2", 0, 40);

        // Test 3: trigger at 0x20 with two post-trigger records; 0x2C is dropped.
        trig_en = 1; trig_pc = 32'h20; post_count = CW'(2);
        tick("t3", 1, 0, 0, z, 0);
        for (int i = 0; i < 12; i++) tick("t3", 0, 0, 1, mk(32'(4*i)), 0);
        chk("t3.triggered", triggered, 1);
        chk("t3.busy", busy, 0);
        chk("t3.count", count, 8);
        chk("t3.first_pc", bus.rd_pc, 32'h0C);
        trig_en = 0;

        // Test 4: backpressure holds the head record, then toggling ready drains.
        hold_pc  = bus.rd_pc;
        hold_cnt = count;
        for (int i = 0; i < 3; i++) begin
            tick("t4", 0, 0, 0, z, 0);
            chk("t4.hold_pc", bus.rd_pc, hold_pc);
            chk("t4.hold_count", count, hold_cnt);
        end
        drain("t4", 1, 80);

        // Test 5: re-arm from DONE after two pops; arm beats the pending read.
        tick("t5", 1, 0, 0, z, 0);
        for (int i = 0; i < 6; i++) tick("t5", 0, 0, 1, mk(32'h100 + 32'(4*i)), 0);
        tick("t5", 0, 1, 0, z, 0);
        tick("t5", 0, 0, 0, z, 1);
        tick("t5", 0, 0, 0, z, 1);
        chk("t5.count_before", count, 4);
        tick("t5", 1, 0, 0, z, 1);
        chk("t5.count", count, 0);
        chk("t5.rd_valid", bus.rd_valid, 0);
        chk("t5.busy", busy, 1);
        tick("t5", 0, 1, 0, z, 0);
        tick("t5", 0, 0, 0, z, 0);

        // Test 6: asynchronous reset in the middle of POST.
        trig_en = 1; trig_pc = 32'h8; post_count = CW'(5);
        tick("t6", 1, 0, 0, z, 0);
        for (int i = 0; i < 4; i++) tick("t6", 0, 0, 1, mk(32'(4*i)), 0);
        chk("t6.pre_triggered", triggered, 1);
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("t6.busy", busy, 0);
        chk("t6.count", count, 0);
        chk("t6.rd_valid", bus.rd_valid, 0);
        chk("t6.triggered", triggered, 0);
        chk("t6.overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        trig_en = 0;
        tick("t6", 0, 0, 0, z, 0);

        // Randomized capture/readout rounds against the model.
        for (int rnd = 0; rnd < 24; rnd++) begin
            string tag;
            tag        = $sformatf("rnd%0d", rnd);
            trig_en    = bit'($urandom_range(0, 1));
            trig_pc    = 32'(4 * $urandom_range(0, 15));
            post_count = CW'($urandom_range(0, DEPTH));
            tick(tag, 1, 0, 0, z, 0);
            for (int c = 0; c < 24 && m_capt; c++)
                tick(tag, 0, ($urandom_range(0, 31) == 0), bit'($urandom_range(0, 3) != 0),
                     rnd_rec(), bit'($urandom_range(0, 1)));
            if (m_capt) tick(tag, 0, 1, bit'($urandom_range(0, 1)), rnd_rec(), 0);
            if (rnd % 6 == 5) begin
                tick(tag, 0, 0, 0, z, 1);
                tick(tag, 1, 0, 0, z, 1);
                tick(tag, 0, 1, 0, z, 0);
            end
            drain(tag, 1, 200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
